// File: rtl/repl_fifo_sets_if.sv
// Request/response bundle for repl_fifo_sets: query, fill, invalidate and flush.
// lock_mask exists only when REPL_LOCK_EN is defined.
interface repl_fifo_sets_if #(
  parameter int SET_ASSOC = 4,
  parameter int SET_NUM   = 64
);
  localparam int WAY_W = $clog2(SET_ASSOC);
  localparam int SET_W = $clog2(SET_NUM);

  logic             query_en;
  logic [SET_W-1:0] query_set;
  logic             repl_valid;
  logic [WAY_W-1:0] repl_index;
  logic             fill_en;
  logic [SET_W-1:0] fill_set;
  logic [WAY_W-1:0] fill_way;
  logic             inval_en;
  logic [SET_W-1:0] inval_set;
  logic [WAY_W-1:0] inval_way;
  logic             flush;
  logic             flush_busy;
`ifdef REPL_LOCK_EN
  logic [SET_ASSOC-1:0] lock_mask;
`endif

  modport master (
    output query_en, query_set, fill_en, fill_set, fill_way,
           inval_en, inval_set, inval_way, flush,
`ifdef REPL_LOCK_EN
           lock_mask,
`endif
    input  repl_valid, repl_index, flush_busy
  );

  modport slave (
    input  query_en, query_set, fill_en, fill_set, fill_way,
           inval_en, inval_set, inval_way, flush,
`ifdef REPL_LOCK_EN
           lock_mask,
`endif
    output repl_valid, repl_index, flush_busy
  );
endinterface

// File: rtl/repl_fifo_sets.sv
// FIFO replacement state for every set of a set-associative cache, with invalid-way
// preference and a one-set-per-cycle flush walker. Optional way locking: REPL_LOCK_EN.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | serve queries, apply fills/invalidates
// FLUSH | clear set flush_cnt each cycle; fills, invals, queries ignored
module repl_fifo_sets #(
  parameter int SET_ASSOC = 4,
  parameter int SET_NUM   = 64,
  parameter int WAY_W     = $clog2(SET_ASSOC),
  parameter int SET_W     = $clog2(SET_NUM)
) (
  input  logic              clk,
  input  logic              rst_n,
  repl_fifo_sets_if.slave   bus
);
  typedef enum logic {IDLE, FLUSH} state_t;

  state_t               state;
  logic [SET_W-1:0]     flush_cnt;
  logic                 flush_busy_q;
  logic                 repl_valid_q;
  logic [WAY_W-1:0]     repl_index_q;
  logic [SET_ASSOC-1:0] valid_q [SET_NUM];
  logic [WAY_W-1:0]     ptr_q   [SET_NUM];

  logic [SET_ASSOC-1:0] q_valid;
  logic [WAY_W-1:0]     q_ptr;
  logic [WAY_W-1:0]     victim;
  logic                 pick_ok;
`ifdef REPL_LOCK_EN
  logic [WAY_W-1:0]     scan_idx;
`endif

  // Queried set as it will look after this cycle's fill/inval (same-set bypass).
  always_comb begin
    q_valid = valid_q[bus.query_set];
    q_ptr   = ptr_q[bus.query_set];
    if (bus.inval_en && bus.inval_set == bus.query_set)
      q_valid[bus.inval_way] = 1'b0;
    if (bus.fill_en && bus.fill_set == bus.query_set) begin
      q_valid[bus.fill_way] = 1'b1;
      if (bus.fill_way == q_ptr)
        q_ptr = q_ptr + 1'b1;
    end
  end

`ifdef REPL_LOCK_EN
  always_comb begin
    victim   = q_ptr;
    scan_idx = '0;
    pick_ok  = ~&bus.lock_mask;
    // Downward scans so the lowest offset / lowest way is the last to win.
    for (int k = SET_ASSOC - 1; k >= 0; k--) begin
      scan_idx = q_ptr + WAY_W'(k);
      if (!bus.lock_mask[scan_idx])
        victim = scan_idx;
    end
    for (int i = SET_ASSOC - 1; i >= 0; i--) begin
      if (!q_valid[i] && !bus.lock_mask[i])
        victim = WAY_W'(i);
    end
  end
`else
  always_comb begin
    victim  = q_ptr;
    pick_ok = 1'b1;
    for (int i = SET_ASSOC - 1; i >= 0; i--) begin
      if (!q_valid[i])
        victim = WAY_W'(i);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      flush_cnt    <= '0;
      flush_busy_q <= 1'b0;
      repl_valid_q <= 1'b0;
      repl_index_q <= '0;
      for (int s = 0; s < SET_NUM; s++) begin
        valid_q[s] <= '0;
        ptr_q[s]   <= '0;
      end
    end else begin
      repl_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.inval_en)
            valid_q[bus.inval_set][bus.inval_way] <= 1'b0;
          // Issued after the invalidate so a same-way fill takes precedence.
          if (bus.fill_en) begin
            valid_q[bus.fill_set][bus.fill_way] <= 1'b1;
            if (bus.fill_way == ptr_q[bus.fill_set])
              ptr_q[bus.fill_set] <= ptr_q[bus.fill_set] + 1'b1;
          end
          if (bus.query_en && pick_ok) begin
            repl_valid_q <= 1'b1;
            repl_index_q <= victim;
          end
          if (bus.flush) begin
            state        <= FLUSH;
            flush_cnt    <= '0;
            flush_busy_q <= 1'b1;
          end
        end
        FLUSH: begin
          valid_q[flush_cnt] <= '0;
          ptr_q[flush_cnt]   <= '0;
          flush_cnt          <= flush_cnt + 1'b1;
          if (flush_cnt == SET_W'(SET_NUM - 1)) begin
            state        <= IDLE;
            flush_busy_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.repl_valid = repl_valid_q;
  assign bus.repl_index = repl_index_q;
  assign bus.flush_busy = flush_busy_q;
endmodule

// File: tb/tb_repl_fifo_sets.sv
// Randomized bench for repl_fifo_sets against a per-set array model of the FIFO/valid rules.
// Exercises lock_mask too when built with REPL_LOCK_EN.
module tb_repl_fifo_sets;
  localparam int SA    = 4;
  localparam int SN    = 64;
  localparam int WAY_W = $clog2(SA);
  localparam int SET_W = $clog2(SN);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  repl_fifo_sets_if #(.SET_ASSOC(SA), .SET_NUM(SN)) bus ();
  repl_fifo_sets #(.SET_ASSOC(SA), .SET_NUM(SN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk  = 0;
  int n_pass = 0;

  bit mvalid [SN][SA];
  int mptr   [SN];
  int mleft, midx;
  bit exp_rv;
  int exp_ri;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    for (int s = 0; s < SN; s++) begin
      mptr[s] = 0;
      for (int w = 0; w < SA; w++) mvalid[s][w] = 1'b0;
    end
    mleft  = 0;
    midx   = 0;
    exp_rv = 1'b0;
    exp_ri = 0;
  endtask

  // Victim: lowest unlocked invalid way, else first unlocked way walking from ptr.
  task automatic model_victim(input int s, input logic [SA-1:0] lk, output bit ok, output int v);
    ok = 1'b0;
    v  = 0;
    for (int w = 0; w < SA && !ok; w++)
      if (!mvalid[s][w] && !lk[w]) begin ok = 1'b1; v = w; end
    for (int k = 0; k < SA && !ok; k++)
      if (!lk[(mptr[s] + k) % SA]) begin ok = 1'b1; v = (mptr[s] + k) % SA; end
  endtask

  task automatic step(input bit qe, input int qs, input bit fe, input int fs, input int fw,
                      input bit ie, input int is, input int iw, input bit fl,
                      input logic [SA-1:0] lk);
    bit ok;
    int v;
    bus.query_en  = qe;  bus.query_set = SET_W'(qs);
    bus.fill_en   = fe;  bus.fill_set  = SET_W'(fs); bus.fill_way  = WAY_W'(fw);
    bus.inval_en  = ie;  bus.inval_set = SET_W'(is); bus.inval_way = WAY_W'(iw);
    bus.flush     = fl;
`ifdef REPL_LOCK_EN
    bus.lock_mask = lk;
`endif
    @(posedge clk);
    exp_rv = 1'b0;
    if (mleft > 0) begin
      mptr[midx] = 0;
      for (int w = 0; w < SA; w++) mvalid[midx][w] = 1'b0;
      midx++;
      mleft--;
    end else begin
      if (ie) mvalid[is][iw] = 1'b0;
      if (fe) begin
        mvalid[fs][fw] = 1'b1;
        if (fw == mptr[fs]) mptr[fs] = (mptr[fs] + 1) % SA;
      end
      if (qe) begin
        model_victim(qs, lk, ok, v);
        if (ok) begin exp_rv = 1'b1; exp_ri = v; end
      end
      if (fl) begin mleft = SN; midx = 0; end
    end
    #1;
    chk("repl_valid", 32'(bus.repl_valid), 32'(exp_rv));
    chk("repl_index", 32'(bus.repl_index), 32'(exp_ri));
    chk("flush_busy", 32'(bus.flush_busy), 32'(mleft > 0));
  endtask

  task automatic idle(); step(0, 0, 0, 0, 0, 0, 0, 0, 0, '0); endtask
  task automatic query(input int s, input logic [SA-1:0] lk); step(1, s, 0, 0, 0, 0, 0, 0, 0, lk); endtask
  task automatic fill(input int s, input int w); step(0, 0, 1, s, w, 0, 0, 0, 0, '0); endtask

  initial begin
    int cnt, guard;
    logic [SA-1:0] lk;
    rst_n = 1'b0;
    bus.query_en = 0; bus.query_set = '0; bus.fill_en = 0; bus.fill_set = '0; bus.fill_way = '0;
    bus.inval_en = 0; bus.inval_set = '0; bus.inval_way = '0; bus.flush = 0;
`ifdef REPL_LOCK_EN
    bus.lock_mask = '0;
`endif
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_repl_valid", 32'(bus.repl_valid), 0);
    chk("rst_repl_index", 32'(bus.repl_index), 0);
    chk("rst_flush_busy", 32'(bus.flush_busy), 0);
    @(negedge clk) rst_n = 1'b1;

    query(5, '0);
    chk("empty_set_valid", 32'(bus.repl_valid), 1);
    chk("empty_set_index", 32'(bus.repl_index), 0);
    idle();
    chk("valid_drops", 32'(bus.repl_valid), 0);

    for (int w = 0; w < SA; w++) fill(3, w);
    query(3, '0);
    chk("ptr_wrap", 32'(bus.repl_index), 0);
    fill(3, 0);
    query(3, '0);
    chk("ptr_advance", 32'(bus.repl_index), 1);
    step(0, 0, 0, 0, 0, 1, 3, 2, 0, '0);
    query(3, '0);
    chk("invalid_pref", 32'(bus.repl_index), 2);
    step(1, 3, 1, 3, 2, 0, 0, 0, 0, '0);
    chk("fill_bypass", 32'(bus.repl_index), 1);

    step(0, 0, 1, 7, 1, 1, 7, 1, 0, '0);
    step(0, 0, 1, 7, 0, 0, 0, 0, 0, '0);
    query(7, '0);
    chk("fill_beats_inval", 32'(bus.repl_index), 2);

`ifdef REPL_LOCK_EN
    for (int w = 0; w < SA; w++) fill(2, w);
    query(2, 4'b0011);
    chk("lock_skip", 32'(bus.repl_index), 2);
    query(2, 4'b1111);
    chk("lock_all", 32'(bus.repl_valid), 0);
`endif

    for (int n = 0; n < 2000; n++) begin
      lk = '0;
`ifdef REPL_LOCK_EN
      lk = ($urandom_range(0, 3) == 0) ? SA'($urandom) : '0;
`endif
      step($urandom_range(0, 1), $urandom_range(0, 7),
           $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, SA - 1),
           $urandom_range(0, 3) == 0, $urandom_range(0, 7), $urandom_range(0, SA - 1),
           $urandom_range(0, 199) == 0, lk);
    end
    guard = 0;
    while (mleft > 0 && guard < 200) begin idle(); guard++; end

    for (int s = 0; s < 8; s++) for (int w = 0; w < SA; w++) fill(s, w);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, '0);
    cnt = int'(bus.flush_busy);
    guard = 0;
    while (bus.flush_busy && guard < 100) begin
      step(1, $urandom_range(0, SN - 1), 1, 0, 1, 1, 0, 0, 1, '0);
      cnt += int'(bus.flush_busy);
      guard++;
    end
    chk("flush_len", cnt, SN);
    for (int s = 0; s < SN; s++) query(s, '0);
    chk("post_flush_idx", 32'(bus.repl_index), 0);

    fill(9, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, '0);
    repeat (10) idle();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_flush_busy", 32'(bus.flush_busy), 0);
    chk("rst_mid_flush_valid", 32'(bus.repl_valid), 0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    query(9, '0);
    chk("rst_clears_state", 32'(bus.repl_index), 0);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
